snitch_tcdm_bank_rw_merge: RTL and testbench
============================================

// Module: snitch_tcdm_bank_rw_merge
// PURPOSE
//  Per-bank merge stage downstream of the split write/read TCDM interconnect pair.
//  Each bank gets two mem requests: one from the write-path interconnect, one from
//  the read-path interconnect. The block arbitrates them onto the single bank port
//  and tracks ownership through the memory latency, so each response returns to the
//  side that issued the request. Sits between the two interconnects and the SRAM banks.
// PARAMETERS
//  NumOut                 8          number of banks (independent lanes)
//  MemoryResponseLatency  1          bank read latency in cycles; must be >= 1
//  mem_req_t              logic      bank request struct {q:{addr,write,amo,data,strb,user}, q_valid}
//  mem_rsp_t              logic      bank response struct {p:{data}, q_ready}
// PORTS
//  clk_i       in   1                 clock
//  rst_ni      in   1                 asynchronous active-low reset
//  wr_req_i    in   NumOut*mem_req_t  bank requests from write-path interconnect
//  wr_rsp_o    out  NumOut*mem_rsp_t  bank responses to write-path interconnect
//  rd_req_i    in   NumOut*mem_req_t  bank requests from read-path interconnect
//  rd_rsp_o    out  NumOut*mem_rsp_t  bank responses to read-path interconnect
//  mem_req_o   out  NumOut*mem_req_t  merged request to bank b
//  mem_rsp_i   in   NumOut*mem_rsp_t  response from bank b
// BEHAVIOUR
//  - Lanes fully independent; all rules below are per bank b.
//  - State per lane: prio (1b, 0=WR,1=RD), owner pipe of MemoryResponseLatency
//    stages, each {vld, src}. Reset: prio=WR, all pipe vld=0, src=WR.
//  - Arbitration (combinational, same cycle):
//    only wr q_valid -> grant WR; only rd q_valid -> grant RD;
//    both -> grant side indicated by prio; none -> no grant.
//  - mem_req_o.q = granted side's q; mem_req_o.q_valid = OR of input q_valid.
//    No grant -> q fields all zero, q_valid=0.
//  - Handshake: fire = mem_req_o.q_valid & mem_rsp_i.q_ready.
//    Granted side q_ready = mem_rsp_i.q_ready; loser/idle side q_ready = 0.
//  - prio update on fire only: if both were valid, prio <= !granted side;
//    single requester or no fire -> prio unchanged. Strict alternation under
//    sustained contention; max wait of a valid requester = 1 fire.
//  - Owner pipe: stage0 <= {fire, granted src}; stage k <= stage k-1 each cycle.
//    Last stage = response owner of current mem_rsp_i.p.
//  - Response routing: owner vld -> owner side p.data = mem_rsp_i.p.data, other
//    side p.data = 0; owner vld=0 -> both p.data = 0. Writes also occupy a slot
//    (data returned is don't-care to the write path).
//  - Response latency through block: 0 extra cycles (pure combinational data path);
//    requests are not registered.
//  - Inputs may drop q_valid without fire; block carries no pending state for them.
//  - Reset mid-operation: pipe cleared asynchronously; responses in flight are
//    dropped (both p.data = 0); prio returns to WR.
//  - Reset output values (inputs idle): mem_req_o all zero; wr/rd rsp all zero.
//  - Illegal: MemoryResponseLatency == 0 -> elaboration $fatal.
//  - Assertions: never wr and rd q_ready both 1 in same lane; owner vld implies a
//    fire exactly MemoryResponseLatency cycles earlier.
// TESTING
//  1 Only wr on bank 2, addr 0x10, data 0xA5, q_ready=1 -> mem_req_o[2] = wr req,
//    wr q_ready=1, rd q_ready=0; rsp data routed to wr side 1 cycle later, rd side 0.
//  2 Both sides valid on bank 0 for 4 cycles, q_ready=1, after reset -> grants
//    WR,RD,WR,RD; each side sees q_ready every other cycle.
//  3 Read 0x20 on bank 5, bank returns 0xDEAD_BEEF at latency 1 -> rd_rsp_o[5].p.data
//    = 0xDEAD_BEEF, wr_rsp_o[5].p.data = 0; repeat with Latency=3, data after 3 cycles.
//  4 Both valid, mem q_ready=0 for 3 cycles then 1 -> no prio change while stalled;
//    first fire grants WR, next RD; no owner pipe entries during stall.
//  5 Back-to-back RD,WR,RD fires with Latency=2 -> responses delivered to rd,wr,rd
//    in order, each exactly 2 cycles after its fire.
//  6 Assert rst_ni low with 2 reads in flight (Latency=2) -> both rsp p.data = 0
//    next cycles; after release, contention grants WR first.

Source files
------------

// File: rtl/snitch_tcdm_bank_rw_merge_if.sv
// Bank request/response types and the per-bank bus bundle shared by the
// write path, the read path and the SRAM side of the merge stage.
`timescale 1ns/1ps
package snitch_tcdm_bank_rw_merge_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [3:0]           amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [UserWidth-1:0] user;
  } mem_q_t;

  typedef struct packed {
    mem_q_t q;
    logic   q_valid;
  } mem_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } mem_p_t;

  typedef struct packed {
    mem_p_t p;
    logic   q_ready;
  } mem_rsp_t;
endpackage

interface snitch_tcdm_bank_rw_merge_if #(
  parameter int unsigned NumOut = 8
);
  import snitch_tcdm_bank_rw_merge_pkg::*;
  mem_req_t [NumOut-1:0] req;
  mem_rsp_t [NumOut-1:0] rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/snitch_tcdm_bank_rw_merge.sv
// Merges the write-path and read-path requests of each bank onto one SRAM port
// and steers each bank response back to the side that issued the request.
`timescale 1ns/1ps
module snitch_tcdm_bank_rw_merge_lane
  import snitch_tcdm_bank_rw_merge_pkg::*;
#(
  parameter int unsigned Latency = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  mem_req_t wr_req_i,
  output mem_rsp_t wr_rsp_o,
  input  mem_req_t rd_req_i,
  output mem_rsp_t rd_rsp_o,
  output mem_req_t mem_req_o,
  input  mem_rsp_t mem_rsp_i
);
  localparam logic SrcWr = 1'b0;
  localparam logic SrcRd = 1'b1;

  logic               prio_q, prio_d;
  logic [Latency-1:0] vld_pipe_q, vld_pipe_d;
  logic [Latency-1:0] src_pipe_q, src_pipe_d;
  logic               both, gnt_wr, gnt_rd, fire;

  always_comb begin
    both   = wr_req_i.q_valid & rd_req_i.q_valid;
    gnt_wr = wr_req_i.q_valid & (~rd_req_i.q_valid | (prio_q == SrcWr));
    gnt_rd = rd_req_i.q_valid & ~gnt_wr;

    mem_req_o = '0;
    if (gnt_wr)      mem_req_o.q = wr_req_i.q;
    else if (gnt_rd) mem_req_o.q = rd_req_i.q;
    mem_req_o.q_valid = wr_req_i.q_valid | rd_req_i.q_valid;
    fire = mem_req_o.q_valid & mem_rsp_i.q_ready;

    wr_rsp_o = '0;
    rd_rsp_o = '0;
    wr_rsp_o.q_ready = gnt_wr & mem_rsp_i.q_ready;
    rd_rsp_o.q_ready = gnt_rd & mem_rsp_i.q_ready;

    // Only a contended fire hands the next turn to the loser.
    prio_d = prio_q;
    if (fire && both) prio_d = gnt_wr ? SrcRd : SrcWr;

    vld_pipe_d    = '0;
    src_pipe_d    = '0;
    vld_pipe_d[0] = fire;
    src_pipe_d[0] = gnt_rd;
    for (int k = 1; k < Latency; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      src_pipe_d[k] = src_pipe_q[k-1];
    end

    // The oldest pipe stage owns whatever the bank returns this cycle.
    if (vld_pipe_q[Latency-1]) begin
      if (src_pipe_q[Latency-1] == SrcRd) rd_rsp_o.p.data = mem_rsp_i.p.data;
      else                                wr_rsp_o.p.data = mem_rsp_i.p.data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= SrcWr;
      vld_pipe_q <= '0;
      src_pipe_q <= '0;
    end else begin
      prio_q     <= prio_d;
      vld_pipe_q <= vld_pipe_d;
      src_pipe_q <= src_pipe_d;
    end
  end

  a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_rsp_o.q_ready && rd_rsp_o.q_ready));
  a_owner_fired: assert property (@(posedge clk_i) disable iff (!rst_ni)
    vld_pipe_q[Latency-1] |-> $past(fire, Latency));
endmodule

module snitch_tcdm_bank_rw_merge #(
  parameter int unsigned NumOut                = 8,
  parameter int unsigned MemoryResponseLatency = 1
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  snitch_tcdm_bank_rw_merge_if.slave  wr,
  snitch_tcdm_bank_rw_merge_if.slave  rd,
  snitch_tcdm_bank_rw_merge_if.master mem
);
  if (MemoryResponseLatency < 1) begin : g_bad_latency
    $fatal(1, "MemoryResponseLatency must be at least 1");
  end

  for (genvar b = 0; b < NumOut; b++) begin : g_lane
    snitch_tcdm_bank_rw_merge_lane #(
      .Latency (MemoryResponseLatency)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_req_i  (wr.req[b]),
      .wr_rsp_o  (wr.rsp[b]),
      .rd_req_i  (rd.req[b]),
      .rd_rsp_o  (rd.rsp[b]),
      .mem_req_o (mem.req[b]),
      .mem_rsp_i (mem.rsp[b])
    );
  end
endmodule

// File: tb/tb_snitch_tcdm_bank_rw_merge.sv
// Drives three merge instances (latency 1, 2, 3) with shared stimulus and checks
// them against a queue-based reference model and a bank model that echoes a hash of the address.
`timescale 1ns/1ps
module tb_snitch_tcdm_bank_rw_merge;
  import snitch_tcdm_bank_rw_merge_pkg::*;
  localparam int NB = 8;
  localparam int NG = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_t [NB-1:0] wr_req;
  mem_req_t [NB-1:0] rd_req;
  logic     [NB-1:0] q_rdy;
  logic [31:0]       bank_data [NG][NB];
  mem_req_t [NB-1:0] mreq [NG];
  mem_rsp_t [NB-1:0] wrsp [NG];
  mem_rsp_t [NB-1:0] rrsp [NG];

  for (genvar g = 0; g < NG; g++) begin : g_dut
    snitch_tcdm_bank_rw_merge_if #(.NumOut(NB)) wr_if ();
    snitch_tcdm_bank_rw_merge_if #(.NumOut(NB)) rd_if ();
    snitch_tcdm_bank_rw_merge_if #(.NumOut(NB)) mem_if ();
    assign wr_if.req = wr_req;
    assign rd_if.req = rd_req;
    always_comb begin
      for (int b = 0; b < NB; b++) begin
        mem_if.rsp[b].p.data  = bank_data[g][b];
        mem_if.rsp[b].q_ready = q_rdy[b];
      end
    end
    assign mreq[g] = mem_if.req;
    assign wrsp[g] = wr_if.rsp;
    assign rrsp[g] = rd_if.rsp;
    snitch_tcdm_bank_rw_merge #(.NumOut(NB), .MemoryResponseLatency(g + 1)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .wr     (wr_if),
      .rd     (rd_if),
      .mem    (mem_if)
    );
  end

  typedef struct { int unsigned due; bit side; logic [31:0] data; } exp_t;
  typedef struct { int unsigned due; logic [31:0] addr; } bank_t;
  exp_t        exp_q  [NG*NB][$];
  bank_t       bank_q [NG*NB][$];
  int unsigned contended [NG*NB];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string nm, input int g, input int b,
                     input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat%0d bank%0d cyc%0d: got %h expected %h", nm, g + 1, b, cyc, act, exp);
    end
  endtask

  // Reference model + monitor: arbitration by contention parity, responses by due cycle.
  always @(negedge clk) begin
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < NB; b++) begin
        int idx;
        bit wv, rv, win_wr, win_rd, fire;
        mem_req_t er;
        logic [31:0] ewd, erd;
        idx = g * NB + b;
        if (!rst_n) begin
          exp_q[idx].delete();
          contended[idx] = 0;
        end
        wv = wr_req[b].q_valid;
        rv = rd_req[b].q_valid;
        win_rd = rv && (!wv || contended[idx][0]);
        win_wr = wv && !win_rd;
        er = '0;
        if (win_wr) er.q = wr_req[b].q;
        else if (win_rd) er.q = rd_req[b].q;
        er.q_valid = wv | rv;
        fire = er.q_valid && q_rdy[b];
        chk("mem_req", g, b, 128'(mreq[g][b]), 128'(er));
        chk("wr_ready", g, b, 128'(wrsp[g][b].q_ready), 128'(win_wr && q_rdy[b]));
        chk("rd_ready", g, b, 128'(rrsp[g][b].q_ready), 128'(win_rd && q_rdy[b]));

        ewd = '0;
        erd = '0;
        while (exp_q[idx].size() > 0 && exp_q[idx][0].due < cyc) void'(exp_q[idx].pop_front());
        if (exp_q[idx].size() > 0 && exp_q[idx][0].due == cyc) begin
          exp_t e;
          e = exp_q[idx].pop_front();
          if (e.side) erd = e.data;
          else        ewd = e.data;
        end
        chk("wr_data", g, b, 128'(wrsp[g][b].p.data), 128'(ewd));
        chk("rd_data", g, b, 128'(rrsp[g][b].p.data), 128'(erd));

        if (rst_n && mreq[g][b].q_valid && q_rdy[b])
          bank_q[idx].push_back('{due: cyc + g + 1, addr: mreq[g][b].q.addr});
        if (rst_n && fire) begin
          exp_q[idx].push_back('{due: cyc + g + 1, side: win_rd, data: hash(er.q.addr)});
          if (wv && rv) contended[idx]++;
        end
      end
    end
  end

  function automatic mem_req_t rnd_req(input bit v);
    mem_req_t r;
    r.q.addr  = $urandom;
    r.q.write = 1'($urandom);
    r.q.amo   = 4'($urandom);
    r.q.data  = $urandom;
    r.q.strb  = 4'($urandom);
    r.q.user  = 1'($urandom);
    r.q_valid = v;
    return r;
  endfunction

  function automatic mem_req_t mk_req(input logic [31:0] addr, input logic wr, input logic [31:0] data);
    mem_req_t r;
    r = '0;
    r.q.addr  = addr;
    r.q.write = wr;
    r.q.data  = data;
    r.q.strb  = 4'hF;
    r.q_valid = 1'b1;
    return r;
  endfunction

  // Bank model: returns hash(addr) at the due cycle of each accepted request, garbage otherwise.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < NB; b++) begin
        int idx;
        idx = g * NB + b;
        while (bank_q[idx].size() > 0 && bank_q[idx][0].due < cyc) void'(bank_q[idx].pop_front());
        if (bank_q[idx].size() > 0 && bank_q[idx][0].due == cyc) bank_data[g][b] = hash(bank_q[idx][0].addr);
        else bank_data[g][b] = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    wr_req = '0;
    rd_req = '0;
    repeat (n) tick();
  endtask

  initial begin
    wr_req = '0;
    rd_req = '0;
    q_rdy  = '0;
    for (int g = 0; g < NG; g++) for (int b = 0; b < NB; b++) bank_data[g][b] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    q_rdy = '1;
    idle(2);

    wr_req[2] = mk_req(32'h10, 1'b1, 32'hA5);
    tick();
    idle(4);

    for (int i = 0; i < 4; i++) begin
      wr_req[0] = rnd_req(1'b1);
      rd_req[0] = rnd_req(1'b1);
      tick();
    end
    idle(4);

    rd_req[5] = mk_req(32'h20, 1'b0, 32'h0);
    tick();
    idle(5);

    q_rdy[1] = 1'b0;
    wr_req[1] = rnd_req(1'b1);
    rd_req[1] = rnd_req(1'b1);
    repeat (3) tick();
    q_rdy[1] = 1'b1;
    repeat (2) tick();
    idle(4);

    rd_req[3] = mk_req(32'h30, 1'b0, 32'h0);
    tick();
    rd_req[3] = '0;
    wr_req[3] = mk_req(32'h34, 1'b1, 32'h1234);
    tick();
    wr_req[3] = '0;
    rd_req[3] = mk_req(32'h38, 1'b0, 32'h0);
    tick();
    idle(5);

    wr_req[4] = rnd_req(1'b1);
    rd_req[4] = rnd_req(1'b1);
    tick();
    wr_req[4] = '0;
    rd_req[4] = mk_req(32'h40, 1'b0, 32'h0);
    tick();
    rd_req[4] = mk_req(32'h44, 1'b0, 32'h0);
    tick();
    rd_req[4] = '0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    wr_req[4] = rnd_req(1'b1);
    rd_req[4] = rnd_req(1'b1);
    repeat (3) tick();
    idle(4);

    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NB; b++) begin
        wr_req[b] = rnd_req($urandom_range(0, 99) < 60);
        rd_req[b] = rnd_req($urandom_range(0, 99) < 60);
        q_rdy[b]  = $urandom_range(0, 99) < 75;
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    q_rdy = '1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
